// File: rtl/sm2_frame_loader.sv
// SM2 request frame loader: gathers a word stream into the wide SM2 frame,
// validates length, masks the message and fires a one-cycle start.
module sm2_frame_loader #(
  parameter int WORD_W  = 32,
  parameter int FIELD_W = 256,
  parameter int LEN_W   = 32,
  parameter int MSG_W   = 1024,
  parameter int FRAME_W = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_last,
  input  logic               cfg_decrypt,
  output logic [FRAME_W-1:0] frame,
  output logic               decrypt,
  output logic               start,
  input  logic               core_valid,
  output logic               busy,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam int FW     = 3*FIELD_W + LEN_W + MSG_W;
  localparam int NWORDS = FW / WORD_W;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam int LO     = FRAME_W - FW;

  if ((FW % WORD_W) != 0 || FRAME_W < FW) begin : g_bad_cfg
    $error("sm2_frame_loader: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_LOAD, S_DRAIN, S_CHECK, S_FIRE, S_WAIT
  } state_t;

  state_t            state, nstate;
  logic [CW-1:0]     cnt;
  logic              acc;
  logic              last_word;
  logic              l_bad;
  logic [LEN_W-1:0]  l_val;
  logic [MSG_W-1:0]  d_val;
  logic [MSG_W-1:0]  dmask;

  assign acc       = s_valid && s_ready;
  assign last_word = (cnt == CW'(NWORDS - 1));
  assign l_val     = frame[LO+MSG_W +: LEN_W];
  assign d_val     = frame[LO +: MSG_W];
  assign l_bad     = {1'b0, l_val} > (LEN_W+1)'(MSG_W);

  // keep message bit i only when i < l
  always_comb begin
    dmask = '0;
    for (int i = 0; i < MSG_W; i++) begin
      dmask[i] = ((LEN_W+1)'(i) < {1'b0, l_val});
    end
  end

  always_comb begin
    nstate  = state;
    s_ready = 1'b0;
    start   = 1'b0;
    busy    = 1'b0;
    case (state)
      S_LOAD: begin
        s_ready = 1'b1;
        if (acc) begin
          if (s_last)
            nstate = last_word ? S_CHECK : S_LOAD;
          else if (last_word)
            nstate = S_DRAIN;
        end
      end
      S_DRAIN: begin
        s_ready = 1'b1;
        if (acc && s_last)
          nstate = S_LOAD;
      end
      S_CHECK: begin
        busy   = 1'b1;
        nstate = l_bad ? S_LOAD : S_FIRE;
      end
      S_FIRE: begin
        busy   = 1'b1;
        start  = 1'b1;
        nstate = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (core_valid)
          nstate = S_LOAD;
      end
      default: nstate = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_LOAD;
      cnt      <= '0;
      frame    <= '0;
      decrypt  <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= nstate;
      err   <= 1'b0;
      if (state == S_LOAD && acc) begin
        frame[FRAME_W-1 -: FW] <=
          {frame[FRAME_W-1-WORD_W -: FW-WORD_W], s_data};
        if (cnt == '0)
          decrypt <= cfg_decrypt;
        cnt <= (s_last || last_word) ? '0 : cnt + CW'(1);
        if (s_last && !last_word) begin
          err      <= 1'b1;
          err_code <= 2'b01;
        end else if (!s_last && last_word) begin
          err      <= 1'b1;
          err_code <= 2'b10;
        end
      end
      if (state == S_CHECK) begin
        if (l_bad) begin
          err      <= 1'b1;
          err_code <= 2'b11;
        end else begin
          frame[LO +: MSG_W] <= d_val & dmask;
        end
      end
    end
  end

endmodule

// File: doc/sm2_frame_loader.md
Name: sm2_frame_loader

Overview:
Stream-to-frame front end for the SM2 core. It collects a narrow word stream from the host into the wide SM2 request frame {k, pbx, pby, l, d, zero-pad}, validates the frame, and masks message bits above l. It then issues a one-cycle start with the latched decrypt mode and holds the frame stable until the core reports valid. Width, field size, and message capacity are parametrised, which generalises the fixed 2048-bit single-shot stimulus.

Parameters:
WORD_W, 32, stream word width in bits
FIELD_W, 256, width of each of k, pbx, pby
LEN_W, 32, width of length field l (message length in bits)
MSG_W, 1024, capacity of message field d
FRAME_W, 2048, output frame width; low FRAME_W-(3*FIELD_W+LEN_W+MSG_W) bits are zero
Constraints (elaboration error otherwise): (3*FIELD_W+LEN_W+MSG_W) % WORD_W == 0; FRAME_W >= 3*FIELD_W+LEN_W+MSG_W.
Derived: NWORDS = (3*FIELD_W+LEN_W+MSG_W)/WORD_W (57 at defaults).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
s_valid  in  1  stream word valid
s_ready  out  1  loader accepts word
s_data  in  WORD_W  stream word, MSB-first order over the frame
s_last  in  1  marks final word of a request
cfg_decrypt  in  1  mode; sampled with first word of request
frame  out  FRAME_W  assembled request to SM2 din
decrypt  out  1  latched mode to SM2 decrypt
start  out  1  one-cycle pulse to SM2 start
core_valid  in  1  SM2 valid (completion)
busy  out  1  high from CHECK until core_valid
err  out  1  one-cycle error pulse
err_code  out  2  01 short frame, 10 long frame, 11 l > MSG_W; held until next err

Behaviour:
- Reset (async, any state): state=LOAD, cnt=0. frame=0, decrypt=0, start=0, busy=0, err=0, err_code=0. s_ready=1 is combinational from LOAD.
- Handshake: a word transfers on clk edge when s_valid && s_ready. s_ready=1 only in LOAD and DRAIN.
- LOAD: each accepted word shifts into the frame field region (first word lands at bits [FRAME_W-1 -: WORD_W]). cnt increments. The word with cnt==0 also latches cfg_decrypt into decrypt. Pad bits always 0.
  - Accepted word, cnt<NWORDS-1, s_last=1: err pulse, err_code=01, cnt=0, stay LOAD. Partial frame is discarded; the next request overwrites it.
  - Accepted word, cnt==NWORDS-1, s_last=1: go CHECK, cnt=0.
  - Accepted word, cnt==NWORDS-1, s_last=0: err pulse, err_code=10, go DRAIN.
- DRAIN: accept and discard words until an accepted word with s_last=1, then go LOAD. No further err pulses.
- CHECK (1 cycle, busy=1):
  - l > MSG_W: err pulse, err_code=11, go LOAD, no start.
  - Otherwise clear d bits [MSG_W-1:l] in frame (l==0 clears all of d; l==MSG_W leaves d unchanged), go FIRE.
- FIRE (1 cycle): start=1, busy=1, go WAIT. Latency: final word accepted at edge N, start high during cycle N+2.
- WAIT: busy=1, frame/decrypt held stable. core_valid=1 returns to LOAD next edge with busy=0. core_valid in LOAD/DRAIN/CHECK/FIRE is ignored.
- frame holds its last value after completion until overwritten by new words.
- s_valid without s_ready: no effect. Data must be held by source (standard valid/ready).

Test Plan:
- Defaults; 57 words encoding k=6, pbx=0, pby=0, l=37, d=0x123456789A, cfg_decrypt=0, s_last on word 57 -> start single pulse 2 cycles after last accept. frame = {k,pbx,pby,l,d,224'b0} with d=0x123456789A (bits above 37 already zero). decrypt=0, busy=1 until core_valid pulse, then s_ready=1.
- Same but l=8, d=0x1FF, cfg_decrypt=1 -> frame d field=0xFF, decrypt=1, start asserted once.
- s_last on word 20 -> err pulse, err_code=01, no start. The following full 57-word request loads correctly and starts.
- 60 words with s_last only on word 60 -> err pulse at word 57 with err_code=10. Words 58-60 accepted and discarded, no start, back in LOAD.
- l=1025 -> err pulse, err_code=11 one cycle after last word, no start, busy low after CHECK.
- rst asserted mid-load (word 30) and again in WAIT -> all outputs 0 immediately, s_ready=1. Next full request behaves as in test 1. Random s_valid gaps and core_valid during LOAD produce no spurious start.
